// File: rtl/ad_ctrl_volt.sv
// Voltmeter ADC front end: ADC sample clock, zero-code calibration, and conversion
// of each later code to sign + magnitude in 10 uV units.
//
// state | meaning
// CAL   | accumulate 2^CAL_LOG2 samples, median = floor(mean)
// DIV   | restoring divides: K_P first, then K_N
// RUN   | convert every sample against the frozen median
`timescale 1ns/1ps
module ad_ctrl_volt #(
   parameter int CAL_LOG2   = 10,
   parameter int FULL_SCALE = 500000,
   parameter int FRAC       = 13
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [7:0]  ad_data,
   output logic        ad_clk,
   output logic        sign,
   output logic [19:0] data
);
   localparam int          ACC_W    = CAL_LOG2 + 8;
   localparam logic [32:0] DIVIDEND = 33'(longint'(FULL_SCALE) << FRAC);
   localparam logic [5:0]  DIV_LAST = 6'd32;

   typedef enum logic [1:0] {CAL, DIV, RUN} state_t;
   state_t state_q, state_d;

   logic                strobe;
   logic [CAL_LOG2-1:0] cal_cnt;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic                cal_last;
   logic [7:0]          median;

   logic [32:0]         dvd_sh;
   logic [7:0]          rem;
   logic [8:0]          rem_sh;
   logic [7:0]          rem_sub;
   logic                ge;
   logic [30:0]         quo;
   logic [31:0]         quo_nx;
   logic [5:0]          div_cnt;
   logic                div_sel;
   logic                div_last;
   logic [7:0]          divisor;
   logic [31:0]         k_p;
   logic [31:0]         k_n;

   logic                smp_vld;
   logic [7:0]          smp_q;
   logic                diff_vld;
   logic                neg_q;
   logic [7:0]          diff_q;
   logic [31:0]         k_sel;
   logic [39:0]         prod;
   logic [39:0]         scaled;
   logic [19:0]         data_nx;

   // ad_clk falls on the strobe edge, so ad_data has had a full high phase to settle
   assign strobe = ad_clk;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ad_clk <= 1'b0;
      end else begin
         ad_clk <= ~ad_clk;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= CAL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CAL:     if (strobe && cal_last) state_d = DIV;
         DIV:     if (div_last && div_sel) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = CAL;
      endcase
   end

   assign cal_last = (cal_cnt == '1);
   assign acc_sum  = acc + {{(ACC_W-8){1'b0}}, ad_data};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cal_cnt <= '0;
         acc     <= '0;
         median  <= '0;
      end else if (state_q == CAL && strobe) begin
         cal_cnt <= cal_cnt + CAL_LOG2'(1);
         acc     <= acc_sum;
         if (cal_last) begin
            median <= acc_sum[ACC_W-1:CAL_LOG2];
         end
      end
   end

   // One quotient bit per cycle; remainder stays below divisor so 8 bits suffice
   assign divisor  = div_sel ? median : (8'd255 - median);
   assign rem_sh   = {rem, dvd_sh[32]};
   assign ge       = (rem_sh >= {1'b0, divisor});
   assign rem_sub  = rem_sh[7:0] - divisor;
   assign quo_nx   = {quo, ge};
   assign div_last = (div_cnt == DIV_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dvd_sh  <= '0;
         rem     <= '0;
         quo     <= '0;
         div_cnt <= '0;
         div_sel <= 1'b0;
         k_p     <= '0;
         k_n     <= '0;
      end else if (state_q == CAL) begin
         dvd_sh  <= DIVIDEND;
         rem     <= '0;
         div_cnt <= '0;
         div_sel <= 1'b0;
      end else if (state_q == DIV) begin
         if (div_last) begin
            if (div_sel) begin
               k_n <= (divisor == 8'd0) ? 32'd0 : quo_nx;
            end else begin
               k_p <= (divisor == 8'd0) ? 32'd0 : quo_nx;
            end
            dvd_sh  <= DIVIDEND;
            rem     <= '0;
            div_cnt <= '0;
            div_sel <= 1'b1;
         end else begin
            dvd_sh  <= {dvd_sh[31:0], 1'b0};
            rem     <= ge ? rem_sub : rem_sh[7:0];
            quo     <= quo_nx[30:0];
            div_cnt <= div_cnt + 6'd1;
         end
      end
   end

   assign k_sel   = neg_q ? k_n : k_p;
   assign prod    = {32'd0, diff_q} * {8'd0, k_sel};
   assign scaled  = prod >> FRAC;
   assign data_nx = (scaled > 40'(FULL_SCALE)) ? 20'(FULL_SCALE) : scaled[19:0];

   // capture -> |difference| -> scaled product; sign and data land together
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         smp_vld  <= 1'b0;
         smp_q    <= '0;
         diff_vld <= 1'b0;
         neg_q    <= 1'b0;
         diff_q   <= '0;
         sign     <= 1'b0;
         data     <= '0;
      end else begin
         smp_vld  <= (state_q == RUN) && strobe;
         if (state_q == RUN && strobe) begin
            smp_q <= ad_data;
         end
         diff_vld <= smp_vld;
         if (smp_vld) begin
            neg_q  <= (smp_q < median);
            diff_q <= (smp_q < median) ? (median - smp_q) : (smp_q - median);
         end
         if (diff_vld) begin
            sign <= neg_q;
            data <= data_nx;
         end
      end
   end

endmodule

// File: tb/tb_ad_ctrl_volt.sv
// Self-checking bench for ad_ctrl_volt: randomized codes against an arithmetic
// model of calibration, scale factors and conversion.
`timescale 1ns/1ps
module tb_ad_ctrl_volt;
   localparam longint FS  = 500000;
   localparam longint DVD = FS * 8192;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [7:0]  ad_data = 8'd127;
   logic        ad_clk;
   logic        sign;
   logic [19:0] data;

   int n_checks = 0;
   int n_fail   = 0;
   int edges;
   int cur_med;
   bit prev_sign;
   int prev_data;

   ad_ctrl_volt dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .ad_data   (ad_data),
      .ad_clk    (ad_clk),
      .sign      (sign),
      .data      (data)
   );

   always #10 sys_clk = ~sys_clk;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) edges <= 0;
      else            edges <= edges + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic longint kp_of(input int m);
      return (m == 255) ? 64'd0 : DVD / longint'(255 - m);
   endfunction

   function automatic longint kn_of(input int m);
      return (m == 0) ? 64'd0 : DVD / longint'(m);
   endfunction

   function automatic void model(input int m, input int code, output bit s, output int d);
      longint mag, v;
      if (code >= m) begin
         s   = 1'b0;
         mag = longint'(code - m);
         v   = (mag * kp_of(m)) / 8192;
      end else begin
         s   = 1'b1;
         mag = longint'(m - code);
         v   = (mag * kn_of(m)) / 8192;
      end
      if (v > FS) v = FS;
      d = int'(v);
   endfunction

   // Returns #1 after the next edge on which ad_clk was high (even edge count)
   task automatic wait_strobe();
      do begin
         @(posedge sys_clk);
         #1;
      end while (edges % 2 != 0);
   endtask

   task automatic calibrate(input int lo, input int hi);
      int sum;
      int v;
      sum = 0;
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         v = int'($urandom_range(hi, lo));
         ad_data = 8'(v);
         sum += v;
         wait_strobe();
         n_checks++;
         if (sign !== 1'b0 || data !== 20'd0) begin
            n_fail++;
            $display("FAIL cal_outputs_zero: sign=%0b data=%0d, expected sign=0 data=0", sign, data);
         end
      end
      cur_med = sum >> 10;
      ad_data = 8'(cur_med);
      for (int i = 0; i < 100; i++) begin
         @(posedge sys_clk);
         #1;
         n_checks++;
         if (sign !== 1'b0 || data !== 20'd0) begin
            n_fail++;
            $display("FAIL div_outputs_zero: sign=%0b data=%0d, expected sign=0 data=0", sign, data);
         end
      end
      n_checks++;
      if (dut.median !== 8'(cur_med)) begin
         n_fail++;
         $display("FAIL median: got %0d, expected %0d", dut.median, cur_med);
      end
      n_checks++;
      if (dut.k_p !== 32'(kp_of(cur_med))) begin
         n_fail++;
         $display("FAIL k_p: got %0d, expected %0d", dut.k_p, kp_of(cur_med));
      end
      n_checks++;
      if (dut.k_n !== 32'(kn_of(cur_med))) begin
         n_fail++;
         $display("FAIL k_n: got %0d, expected %0d", dut.k_n, kn_of(cur_med));
      end
      prev_sign = 1'b0;
      prev_data = 0;
   endtask

   task automatic apply_code(input int code, input string tag);
      bit es;
      int ed;
      model(cur_med, code, es, ed);
      ad_data = 8'(code);
      wait_strobe();
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (sign !== prev_sign || data !== 20'(prev_data)) begin
            n_fail++;
            $display("FAIL %s_hold%0d: sign=%0b data=%0d, expected sign=%0b data=%0d",
                     tag, k, sign, data, prev_sign, prev_data);
         end
         @(posedge sys_clk);
         #1;
      end
      n_checks++;
      if (sign !== es || data !== 20'(ed)) begin
         n_fail++;
         $display("FAIL %s code=%0d: sign=%0b data=%0d, expected sign=%0b data=%0d",
                  tag, code, sign, data, es, ed);
      end
      prev_sign = es;
      prev_data = ed;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      #35;
      n_checks++;
      if (ad_clk !== 1'b0 || sign !== 1'b0 || data !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: ad_clk=%0b sign=%0b data=%0d, expected all 0", ad_clk, sign, data);
      end
      n_checks++;
      if (dut.median !== 8'd0 || dut.k_p !== 32'd0 || dut.k_n !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_regs: median=%0d k_p=%0d k_n=%0d, expected 0", dut.median, dut.k_p, dut.k_n);
      end
   endtask

   task automatic test_adclk();
      time t_rise;
      bit  have_rise;
      bit  last;
      have_rise = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      #1;
      n_checks++;
      if (ad_clk !== 1'b0) begin
         n_fail++;
         $display("FAIL adclk_release: got %0b, expected 0", ad_clk);
      end
      last = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge sys_clk);
         #1;
         n_checks++;
         if (ad_clk !== edges[0]) begin
            n_fail++;
            $display("FAIL adclk_toggle: got %0b, expected %0b", ad_clk, edges[0]);
         end
         if (ad_clk && !last) begin
            if (have_rise) begin
               n_checks++;
               if ($time - t_rise != 40) begin
                  n_fail++;
                  $display("FAIL adclk_period: got %0t, expected 40ns", $time - t_rise);
               end
            end
            t_rise    = $time;
            have_rise = 1'b1;
         end else if (!ad_clk && last && have_rise) begin
            n_checks++;
            if ($time - t_rise != 20) begin
               n_fail++;
               $display("FAIL adclk_high_time: got %0t, expected 20ns", $time - t_rise);
            end
         end
         last = ad_clk;
      end
   endtask

   task automatic test_cal_127();
      calibrate(127, 127);
      n_checks++;
      if (dut.k_p !== 32'd32000000 || dut.k_n !== 32'd32251968) begin
         n_fail++;
         $display("FAIL k_127: k_p=%0d k_n=%0d, expected 32000000 32251968", dut.k_p, dut.k_n);
      end
      apply_code(127, "zero");
   endtask

   task automatic test_points();
      apply_code(255, "pos_full");
      n_checks++;
      if (data !== 20'd500000) begin
         n_fail++;
         $display("FAIL pos_full_const: data=%0d, expected 500000", data);
      end
      apply_code(191, "pos_half");
      apply_code(0, "neg_full");
      n_checks++;
      if (sign !== 1'b1 || data !== 20'd499999) begin
         n_fail++;
         $display("FAIL neg_full_const: sign=%0b data=%0d, expected 1 499999", sign, data);
      end
      apply_code(126, "neg_lsb");
      apply_code(128, "pos_lsb");
   endtask

   task automatic test_ramp();
      int code;
      int last_d;
      last_d = 0;
      for (int v = 0; v <= 5000; v += 125) begin
         code = 127 + v * 128 / 5000;
         apply_code(code, "ramp_pos");
         n_checks++;
         if (sign !== 1'b0 || int'(data) < last_d) begin
            n_fail++;
            $display("FAIL ramp_pos_monotonic: sign=%0b data=%0d, expected sign=0 data>=%0d", sign, data, last_d);
         end
         last_d = int'(data);
      end
      last_d = 500000;
      for (int v = 5000; v >= 0; v -= 125) begin
         code = (5000 - v) * 127 / 5000;
         apply_code(code, "ramp_neg");
         n_checks++;
         if (sign !== (code < 127) || int'(data) > last_d) begin
            n_fail++;
            $display("FAIL ramp_neg_monotonic: sign=%0b data=%0d, expected sign=%0b data<=%0d",
                     sign, data, code < 127, last_d);
         end
         last_d = int'(data);
      end
   endtask

   task automatic test_random(input int n);
      for (int i = 0; i < n; i++) begin
         apply_code(int'($urandom_range(255, 0)), "random");
      end
   endtask

   task automatic test_div_zero();
      calibrate(255, 255);
      apply_code(255, "dz_p_top");
      apply_code(0, "dz_p_bottom");
      apply_code(200, "dz_p_mid");
      calibrate(0, 0);
      apply_code(0, "dz_n_zero");
      apply_code(255, "dz_n_top");
      apply_code(77, "dz_n_mid");
   endtask

   task automatic test_random_cal();
      calibrate(90, 170);
      test_random(25);
   endtask

   task automatic test_reset_mid();
      calibrate(127, 127);
      apply_code(255, "pre_reset");
      @(posedge sys_clk);
      #5;
      sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if (sign !== 1'b0 || data !== 20'd0 || ad_clk !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: ad_clk=%0b sign=%0b data=%0d, expected all 0", ad_clk, sign, data);
      end
      calibrate(64, 64);
      n_checks++;
      if (dut.k_p !== 32'd21445026) begin
         n_fail++;
         $display("FAIL k_p_64: got %0d, expected 21445026", dut.k_p);
      end
      apply_code(255, "recal_top");
      n_checks++;
      if (data !== 20'd499999) begin
         n_fail++;
         $display("FAIL recal_top_const: data=%0d, expected 499999", data);
      end
      test_random(15);
   endtask

   initial begin
      test_reset();
      test_adclk();
      test_cal_127();
      test_points();
      test_ramp();
      test_random(40);
      test_div_zero();
      test_random_cal();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
